// File: rtl/twiddle_addr_gen_pkg.sv
// rtl/twiddle_addr_gen_pkg.sv - shared FSM type, default size and log2 clamp for the twiddle address generator
package twiddle_pkg;

    localparam int TW_N_MAX_DEFAULT = 64;

    typedef enum logic [1:0] {
        TW_IDLE  = 2'd0,
        TW_RUN   = 2'd1,
        TW_DRAIN = 2'd2
    } tw_state_e;

    // Runtime FFT size is kept within 2..N_MAX so every frame has at least one stage.
    function automatic int tw_log2n_clamp(input int log2_n, input int log2_nmax);
        if (log2_n < 1) begin
            return 1;
        end
        if (log2_n > log2_nmax) begin
            return log2_nmax;
        end
        return log2_n;
    endfunction

endpackage

// File: rtl/twiddle_addr_gen_if.sv
// rtl/twiddle_addr_gen_if.sv - control and per-stage address bundle of the twiddle address generator
interface twiddle_addr_gen_if
    import twiddle_pkg::*;
#(
    parameter int N_MAX = TW_N_MAX_DEFAULT
);
    localparam int LOG2_NMAX  = $clog2(N_MAX);
    localparam int NUM_STAGES = LOG2_NMAX;
    localparam int ADDR_W     = LOG2_NMAX - 1;
    localparam int LN_W       = $clog2(LOG2_NMAX + 1);

    logic                                start;
    logic [LN_W-1:0]                     log2_n;
    logic                                inverse;
    logic                                valid_in;
    logic [NUM_STAGES-1:0]               stage_en;
    logic [NUM_STAGES-1:0][ADDR_W-1:0]   tw_addr;
    logic                                tw_conj;
    logic                                busy;
    logic                                frame_done;

    modport master (
        output start, log2_n, inverse, valid_in,
        input  stage_en, tw_addr, tw_conj, busy, frame_done
    );

    modport slave (
        input  start, log2_n, inverse, valid_in,
        output stage_en, tw_addr, tw_conj, busy, frame_done
    );

endinterface

// File: rtl/twiddle_stage_ptr.sv
// rtl/twiddle_stage_ptr.sv - per-stage twiddle ROM pointer, advances by a runtime step on each enable
module twiddle_stage_ptr #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [ADDR_W-1:0] step,
    output logic [ADDR_W-1:0] pointer
);

    // Wrap at N_MAX/2 is the natural ADDR_W-bit overflow of the accumulator.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pointer <= '0;
        end else if (enable) begin
            pointer <= pointer + step;
        end
    end

endmodule

// File: rtl/twiddle_addr_gen.sv
// rtl/twiddle_addr_gen.sv - runtime-size multi-stage twiddle address generator for radix-2 SDF FFT; TWIDDLE_INV_EN enables tw_conj
module twiddle_addr_gen
    import twiddle_pkg::*;
#(
    parameter int N_MAX     = TW_N_MAX_DEFAULT,
    parameter int STAGE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    twiddle_addr_gen_if.slave tw
);

    localparam int LOG2_NMAX  = $clog2(N_MAX);
    localparam int NUM_STAGES = LOG2_NMAX;
    localparam int ADDR_W     = LOG2_NMAX - 1;
    localparam int LN_W       = $clog2(LOG2_NMAX + 1);
    localparam int CNT_W      = LOG2_NMAX + 1;
    localparam int CHAIN_W    = (NUM_STAGES - 1) * STAGE_LAT + 1;

    tw_state_e                          state_q, state_d;
    logic                               load;
    logic                               accept;
    logic                               busy_c;
    logic                               done_c;
    logic [LN_W-1:0]                    l_q;
    logic [31:0]                        l_ext;
    logic [CNT_W-1:0]                   n_val;
    logic [CNT_W-1:0]                   in_cnt_q;
    logic [CNT_W-1:0]                   out_cnt_q;
    logic [CHAIN_W-1:0]                 chain_q;
    logic [NUM_STAGES-1:0]              en_m;
    logic [NUM_STAGES-1:0]              stage_live;
    logic                               last_en;
    logic [NUM_STAGES-1:0][ADDR_W-1:0]  step;
    logic [NUM_STAGES-1:0][ADDR_W-1:0]  ptr;
    logic [NUM_STAGES-1:0][ADDR_W-1:0]  addr_m;

    assign l_ext  = 32'(l_q);
    assign n_val  = CNT_W'(1) << l_q;
    assign accept = (state_q == TW_RUN) && tw.valid_in;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        busy_c  = (state_q != TW_IDLE);
        done_c  = 1'b0;
        case (state_q)
            TW_IDLE: begin
                if (tw.start) begin
                    state_d = TW_RUN;
                    load    = 1'b1;
                end
            end
            TW_RUN: begin
                if (accept && (in_cnt_q == n_val - CNT_W'(1))) begin
                    state_d = TW_DRAIN;
                end
            end
            TW_DRAIN: begin
                if (out_cnt_q == n_val) begin
                    done_c  = 1'b1;
                    state_d = TW_IDLE;
                end
            end
            default: state_d = TW_IDLE;
        endcase
    end

    // out_cnt tracks the last live stage from frame start, since its first enables land while still in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TW_IDLE;
            l_q       <= LN_W'(1);
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                l_q       <= LN_W'(tw_log2n_clamp(int'(tw.log2_n), LOG2_NMAX));
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (accept) begin
                    in_cnt_q <= in_cnt_q + CNT_W'(1);
                end
                if (last_en) begin
                    out_cnt_q <= out_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[CHAIN_W-2:0], accept};
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        assign stage_live[s] = (32'(s) < l_ext);
        assign en_m[s]       = chain_q[s*STAGE_LAT] & stage_live[s];
        assign step[s]       = ADDR_W'((32'(N_MAX) >> l_q) << s);
        assign addr_m[s]     = stage_live[s] ? ptr[s] : '0;

        twiddle_stage_ptr #(
            .ADDR_W (ADDR_W)
        ) u_ptr (
            .clk     (clk),
            .reset   (reset),
            .clear   (load),
            .enable  (en_m[s]),
            .step    (step[s]),
            .pointer (ptr[s])
        );
    end

    always_comb begin
        last_en = 1'b0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (32'(s) == l_ext - 32'd1) begin
                last_en = en_m[s];
            end
        end
    end

`ifdef TWIDDLE_INV_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            inv_q <= 1'b0;
        end else if (load) begin
            inv_q <= tw.inverse;
        end
    end

    assign tw.tw_conj = inv_q & busy_c;
`else
    logic unused_inverse;
    assign unused_inverse = tw.inverse;
    assign tw.tw_conj     = 1'b0;
`endif

    assign tw.stage_en   = en_m;
    assign tw.tw_addr    = addr_m;
    assign tw.busy       = busy_c;
    assign tw.frame_done = done_c;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// tb/tb_twiddle_addr_gen.sv - self-checking bench for twiddle_addr_gen (N_MAX=16, STAGE_LAT=1)
module tb_twiddle_addr_gen;

    localparam int NM  = 16;
    localparam int LAT = 1;
    localparam int NS  = 4;
`ifdef TWIDDLE_INV_EN
    localparam int INV_EN = 1;
`else
    localparam int INV_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    twiddle_addr_gen_if #(.N_MAX(NM)) ifc ();

    twiddle_addr_gen #(
        .N_MAX     (NM),
        .STAGE_LAT (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tw    (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int tp;
    bit chk_on = 1'b0;

    // Frame model: start cycle, clamped L, inverse flag, accepted-sample cycles, frame_done cycle.
    int m_start = -1;
    int m_L     = 1;
    int m_done  = -1;
    bit m_inv   = 1'b0;
    int m_acc[$];

    int obs[NS][32];
    int obs_n[NS];
    int done_cnt = 0;
    int last_en3 = -1;

    bit       act;
    bit [3:0] exp_en;
    int       exp_a[NS];

    int e_l4_s0[16] = '{0,1,2,3,4,5,6,7,0,1,2,3,4,5,6,7};
    int e_l4_s1[16] = '{0,2,4,6,0,2,4,6,0,2,4,6,0,2,4,6};
    int e_l4_s2[16] = '{0,4,0,4,0,4,0,4,0,4,0,4,0,4,0,4};
    int e_zero[16]  = '{default:0};
    int e_l3_s0[16] = '{0,2,4,6,0,2,4,6,0,0,0,0,0,0,0,0};
    int e_l3_s1[16] = '{0,4,0,4,0,4,0,4,0,0,0,0,0,0,0,0};
    int e_l2_s0[16] = '{0,4,0,4,0,0,0,0,0,0,0,0,0,0,0,0};

    task automatic chk(input string nm, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, actual, expected);
        end
    endtask

    function automatic int mclamp(input int v);
        if (v < 1) return 1;
        if (v > 4) return 4;
        return v;
    endfunction

    always begin
        @(posedge clk);
        cyc = cyc + 1;
        tp  = cyc - 1;
        if (reset) begin
            m_start = -1;
            m_done  = -1;
            m_acc.delete();
            chk_on  = 1'b1;
        end else if (m_start < 0 || (m_done >= 0 && tp > m_done)) begin
            if (ifc.start) begin
                m_start = tp;
                m_L     = mclamp(int'(ifc.log2_n));
                m_inv   = ifc.inverse;
                m_done  = -1;
                m_acc.delete();
            end
        end else if (m_acc.size() < (1 << m_L) && ifc.valid_in) begin
            m_acc.push_back(tp);
            if (m_acc.size() == (1 << m_L)) begin
                m_done = tp + 1 + (m_L - 1) * LAT + 1;
            end
        end
    end

    always begin
        @(negedge clk);
        if (chk_on) begin
            act = (m_start >= 0) && (cyc > m_start) && (m_done < 0 || cyc <= m_done);
            chk("busy", int'(ifc.busy), int'(act));
            chk("frame_done", int'(ifc.frame_done), int'(m_done >= 0 && cyc == m_done));
            chk("tw_conj", int'(ifc.tw_conj), int'(act && m_inv && INV_EN == 1));
            exp_en = '0;
            for (int s = 0; s < NS; s++) begin
                exp_a[s] = 0;
                for (int k = 0; k < m_acc.size(); k++) begin
                    if (s < m_L && m_acc[k] + 1 + s * LAT == cyc) begin
                        exp_en[s] = 1'b1;
                        exp_a[s]  = (k * ((NM >> m_L) << s)) % (NM / 2);
                    end
                end
            end
            chk("stage_en", int'(ifc.stage_en), int'(exp_en));
            for (int s = 0; s < NS; s++) begin
                if (exp_en[s] || m_start < 0 || s >= m_L) begin
                    chk($sformatf("tw_addr%0d", s), int'(ifc.tw_addr[s]), exp_a[s]);
                end
            end
        end
        for (int s = 0; s < NS; s++) begin
            if (ifc.stage_en[s] && obs_n[s] < 32) begin
                obs[s][obs_n[s]] = int'(ifc.tw_addr[s]);
                obs_n[s]++;
            end
        end
        if (ifc.stage_en[3]) last_en3 = cyc;
        if (ifc.frame_done)  done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        for (int s = 0; s < NS; s++) obs_n[s] = 0;
    endtask

    task automatic start_frame(input int l, input bit inv, output int ts);
        ifc.start   = 1'b1;
        ifc.log2_n  = l[2:0];
        ifc.inverse = inv;
        ts = cyc;
        tick();
        ifc.start   = 1'b0;
        ifc.inverse = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            ifc.valid_in = 1'b1;
            tick();
            if (gaps) begin
                ifc.valid_in = 1'b0;
                tick();
            end
        end
        ifc.valid_in = 1'b0;
    endtask

    task automatic wait_done(input bit poke_start, output int dc);
        dc = -1;
        for (int i = 0; i < 200 && dc < 0; i++) begin
            if (ifc.frame_done) begin
                dc = cyc;
                if (poke_start) begin
                    ifc.start  = 1'b1;
                    ifc.log2_n = 3'd4;
                end
            end
            tick();
            ifc.start = 1'b0;
        end
        if (dc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_obs(input string nm, input int s, input int n, input int e[16]);
        chk({nm, "_count"}, obs_n[s], n);
        for (int i = 0; i < n && i < obs_n[s] && i < 16; i++) begin
            chk(nm, obs[s][i], e[i]);
        end
    endtask

    int ts, dc, snap;

    initial begin
        reset        = 1'b1;
        ifc.start    = 1'b0;
        ifc.log2_n   = '0;
        ifc.inverse  = 1'b0;
        ifc.valid_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ifc.start    = i[0];
            ifc.valid_in = ~i[0];
            ifc.inverse  = i[1];
            ifc.log2_n   = i[2:0];
            tick();
        end
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_stage_en", int'(ifc.stage_en), 0);
        ifc.start = 1'b0; ifc.valid_in = 1'b0; ifc.inverse = 1'b0; ifc.log2_n = '0;
        reset = 1'b0;
        tick(); tick();

        // L=4 continuous, stray valid_in in DRAIN and start on the frame_done cycle
        clear_obs();
        start_frame(4, 1'b0, ts);
        feed(16, 1'b0);
        ifc.valid_in = 1'b1; tick(); tick(); ifc.valid_in = 1'b0;
        wait_done(1'b1, dc);
        chk("t2_done_lat", dc - ts, 21);
        chk("t2_idle_busy", int'(ifc.busy), 0);
        chk_obs("t2_s0", 0, 16, e_l4_s0);
        chk_obs("t2_s1", 1, 16, e_l4_s1);
        chk_obs("t2_s2", 2, 16, e_l4_s2);
        chk_obs("t2_s3", 3, 16, e_zero);
        tick(); tick();

        // L=3: stage 3 stays masked
        clear_obs();
        snap = done_cnt;
        start_frame(3, 1'b0, ts);
        feed(8, 1'b0);
        wait_done(1'b0, dc);
        chk("t3_done_lat", dc - ts, 12);
        chk_obs("t3_s0", 0, 8, e_l3_s0);
        chk_obs("t3_s1", 1, 8, e_l3_s1);
        chk_obs("t3_s3", 3, 0, e_zero);
        tick(); tick();
        chk("t3_done_once", done_cnt - snap, 1);

        // L=4 with alternating valid_in
        clear_obs();
        start_frame(4, 1'b0, ts);
        feed(16, 1'b1);
        wait_done(1'b0, dc);
        chk("t4_done_after_en3", dc, last_en3 + 1);
        chk("t4_done_lat", dc - ts, 36);
        chk_obs("t4_s0", 0, 16, e_l4_s0);
        chk_obs("t4_s2", 2, 16, e_l4_s2);
        tick();

        // inverse flag
        start_frame(2, 1'b1, ts);
        chk("t5_conj_run", int'(ifc.tw_conj), INV_EN);
        feed(4, 1'b0);
        wait_done(1'b0, dc);
        chk("t5_conj_idle", int'(ifc.tw_conj), 0);
        tick();

        // reset mid-RUN, then L=2 from fresh pointers
        start_frame(4, 1'b0, ts);
        feed(5, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        snap = done_cnt;
        for (int i = 0; i < 30; i++) tick();
        chk("t6_no_done", done_cnt - snap, 0);
        clear_obs();
        start_frame(2, 1'b0, ts);
        feed(4, 1'b0);
        wait_done(1'b0, dc);
        chk("t6_done_lat", dc - ts, 7);
        chk_obs("t6_s0", 0, 4, e_l2_s0);
        chk_obs("t6_s1", 1, 4, e_zero);
        tick();

        // log2_n clamping at both ends
        clear_obs();
        start_frame(0, 1'b0, ts);
        feed(2, 1'b0);
        wait_done(1'b0, dc);
        chk("t7_lo_done_lat", dc - ts, 4);
        chk_obs("t7_lo_s0", 0, 2, e_zero);
        tick();
        clear_obs();
        start_frame(7, 1'b0, ts);
        feed(16, 1'b0);
        wait_done(1'b0, dc);
        chk("t7_hi_done_lat", dc - ts, 21);
        chk_obs("t7_hi_s1", 1, 16, e_l4_s1);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
